// File: rtl/ctrl_pipe_reg.sv
// ctrl_pipe_reg: DEPTH-stage control-word pipeline register with stall, flush and
// per-stage valid tracking. Write-enable bits (WE_MASK) of an invalid last stage are
// forced low so a bubble can never commit a write.
// Optional perf counters are built when CTRL_PIPE_PERF_EN is defined; otherwise
// stall_cnt_o/flush_cnt_o read zero. The port list is the same in both builds.
module ctrl_pipe_reg #(
   parameter int unsigned          WIDTH   = 8,
   parameter int unsigned          DEPTH   = 1,
   parameter logic [WIDTH-1:0]     RST_VAL = '0,
   parameter logic [WIDTH-1:0]     WE_MASK = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [WIDTH-1:0]             ctrl_i,
   input  logic                         valid_i,
   input  logic                         stall_i,
   input  logic                         flush_i,
   output logic [WIDTH-1:0]             ctrl_o,
   output logic                         valid_o,
   output logic [DEPTH-1:0]             stage_valid_o,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
   output logic [15:0]                  stall_cnt_o,
   output logic [15:0]                  flush_cnt_o
);

   localparam int unsigned OccW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [OccW-1:0]  occ;

   // Stage registers: flush beats stall, stall beats advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < int'(DEPTH); k++) data_q[k] <= RST_VAL;
         valid_q <= '0;
      end else if (flush_i) begin
         // The incoming word is discarded along with everything in flight.
         for (int k = 0; k < int'(DEPTH); k++) data_q[k] <= RST_VAL;
         valid_q <= '0;
      end else if (!stall_i) begin
         data_q[0]  <= ctrl_i;
         valid_q[0] <= valid_i;
         for (int k = 1; k < int'(DEPTH); k++) begin
            data_q[k]  <= data_q[k-1];
            valid_q[k] <= valid_q[k-1];
         end
      end
   end

   // Popcount of the per-stage valid bits.
   always_comb begin
      occ = '0;
      for (int k = 0; k < int'(DEPTH); k++) occ = occ + OccW'(valid_q[k]);
   end

   // Output gating: only WE bits are masked; other bits stay visible for debug.
   always_comb begin
      valid_o = valid_q[DEPTH-1];
      ctrl_o  = valid_o ? data_q[DEPTH-1] : (data_q[DEPTH-1] & ~WE_MASK);
   end

   assign stage_valid_o = valid_q;
   assign occupancy_o   = occ;

`ifdef CTRL_PIPE_PERF_EN
   logic [15:0] stall_cnt_q;
   logic [15:0] flush_cnt_q;

   // Saturating event counters, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 16'h0000;
         flush_cnt_q <= 16'h0000;
      end else begin
         if (flush_i && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
         if (stall_i && !flush_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`else
   assign stall_cnt_o = 16'h0000;
   assign flush_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// Bench for ctrl_pipe_reg: a DEPTH=1 and a DEPTH=3 instance share one stimulus stream.
// Accepted words are queued per instance and popped whenever the last stage advances.
module tb_ctrl_pipe_reg;

   localparam logic [7:0] RstVal = 8'h5F;
   localparam logic [7:0] WeMask = 8'h03;
   localparam logic [7:0] Bubble = 8'h5C;  // RstVal & ~WeMask

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ctrl_in;
   logic       valid_in, stall_in, flush_in;

   logic [7:0]  c1, c3;
   logic        v1, v3;
   logic [0:0]  sv1, occ1;
   logic [2:0]  sv3;
   logic [1:0]  occ3;
   logic [15:0] sc1, fc1, sc3, fc3;

   int checks   = 0;
   int failures = 0;
   int exp_stall = 0;
   int exp_flush = 0;
   logic [7:0] sb1 [$];
   logic [7:0] sb3 [$];

   always #5 clk = ~clk;

   ctrl_pipe_reg #(.WIDTH(8), .DEPTH(1), .RST_VAL(RstVal), .WE_MASK(WeMask)) dut1 (
      .clk(clk), .rst(rst), .ctrl_i(ctrl_in), .valid_i(valid_in), .stall_i(stall_in),
      .flush_i(flush_in), .ctrl_o(c1), .valid_o(v1), .stage_valid_o(sv1), .occupancy_o(occ1),
      .stall_cnt_o(sc1), .flush_cnt_o(fc1)
   );

   ctrl_pipe_reg #(.WIDTH(8), .DEPTH(3), .RST_VAL(RstVal), .WE_MASK(WeMask)) dut3 (
      .clk(clk), .rst(rst), .ctrl_i(ctrl_in), .valid_i(valid_in), .stall_i(stall_in),
      .flush_i(flush_in), .ctrl_o(c3), .valid_o(v3), .stage_valid_o(sv3), .occupancy_o(occ3),
      .stall_cnt_o(sc3), .flush_cnt_o(fc3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_cnt(input int n);
`ifdef CTRL_PIPE_PERF_EN
      return 32'(n);
`else
      return 32'(n & 0);
`endif
   endfunction

   task automatic drive(input logic [7:0] c, input logic v, input logic s, input logic f);
      ctrl_in  = c;
      valid_in = v;
      stall_in = s;
      flush_in = f;
   endtask

   // One clock: update scoreboard and counter model, take the edge, pop on advance.
   task automatic step();
      logic adv;
      logic [7:0] e;
      adv = !rst && !stall_in && !flush_in;
      if (!rst) begin
         if (flush_in) exp_flush = (exp_flush < 65535) ? exp_flush + 1 : exp_flush;
         else if (stall_in) exp_stall = (exp_stall < 65535) ? exp_stall + 1 : exp_stall;
      end
      if (rst || flush_in) begin
         sb1.delete();
         sb3.delete();
      end else if (adv && valid_in) begin
         sb1.push_back(ctrl_in);
         sb3.push_back(ctrl_in);
      end
      @(posedge clk);
      #1;
      if (adv && v1) begin
         e = (sb1.size() > 0) ? sb1.pop_front() : 8'hxx;
         check("sb_d1", {24'h0, c1}, {24'h0, e});
      end
      if (adv && v3) begin
         e = (sb3.size() > 0) ? sb3.pop_front() : 8'hxx;
         check("sb_d3", {24'h0, c3}, {24'h0, e});
      end
   endtask

   task automatic check_cnts(input string tag);
      check({tag, "_stall1"}, {16'h0, sc1}, exp_cnt(exp_stall));
      check({tag, "_flush1"}, {16'h0, fc1}, exp_cnt(exp_flush));
      check({tag, "_stall3"}, {16'h0, sc3}, exp_cnt(exp_stall));
      check({tag, "_flush3"}, {16'h0, fc3}, exp_cnt(exp_flush));
   endtask

   initial begin
      rst = 1'b1;
      drive(8'h00, 1'b0, 1'b0, 1'b0);
      step();
      step();
      // Reset state
      check("rst_c1", {24'h0, c1}, {24'h0, Bubble});
      check("rst_v1", {31'h0, v1}, 32'h0);
      check("rst_c3", {24'h0, c3}, {24'h0, Bubble});
      check("rst_sv3", {29'h0, sv3}, 32'h0);
      check("rst_occ3", {30'h0, occ3}, 32'h0);
      check_cnts("rst");
      rst = 1'b0;

      // DEPTH=1: valid word passes, invalid word has WE bits masked
      drive(8'hA7, 1'b1, 1'b0, 1'b0); step();
      check("d1_valid_c", {24'h0, c1}, 32'hA7);
      check("d1_valid_v", {31'h0, v1}, 32'h1);
      check("d1_occ", {31'h0, occ1}, 32'h1);
      drive(8'hA7, 1'b0, 1'b0, 1'b0); step();
      check("d1_bubble_c", {24'h0, c1}, 32'hA4);
      check("d1_bubble_v", {31'h0, v1}, 32'h0);
      check("d1_bubble_sv", {31'h0, sv1}, 32'h0);
      drive(8'hFF, 1'b0, 1'b0, 1'b0);
      repeat (3) step();
      check("d3_bubble_c", {24'h0, c3}, 32'hFC);
      check("d3_bubble_occ", {30'h0, occ3}, 32'h0);

      // DEPTH=3 stream with a two-cycle stall
      drive(8'h11, 1'b1, 1'b0, 1'b0); step();
      check("d3_occ1", {30'h0, occ3}, 32'h1);
      drive(8'h22, 1'b1, 1'b0, 1'b0); step();
      drive(8'h33, 1'b1, 1'b0, 1'b0); step();
      check("d3_lat3_c", {24'h0, c3}, 32'h11);
      check("d3_lat3_occ", {30'h0, occ3}, 32'h3);
      drive(8'hEE, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step();
         check("d3_stall_c", {24'h0, c3}, 32'h11);
         check("d3_stall_occ", {30'h0, occ3}, 32'h3);
      end
      drive(8'h44, 1'b1, 1'b0, 1'b0); step();
      check("d3_after_stall", {24'h0, c3}, 32'h22);
      drive(8'h55, 1'b1, 1'b0, 1'b0); step();
      check("d3_after_stall2", {24'h0, c3}, 32'h33);

      // Fill, then flush+stall together; the word presented during flush must vanish
      drive(8'h66, 1'b1, 1'b0, 1'b0); step();
      drive(8'h77, 1'b1, 1'b0, 1'b0); step();
      drive(8'h88, 1'b1, 1'b0, 1'b0); step();
      check("d3_full_sv", {29'h0, sv3}, 32'h7);
      drive(8'h99, 1'b1, 1'b1, 1'b1); step();
      check("flush_sv3", {29'h0, sv3}, 32'h0);
      check("flush_c3", {24'h0, c3}, {24'h0, Bubble});
      check("flush_v3", {31'h0, v3}, 32'h0);
      check("flush_c1", {24'h0, c1}, {24'h0, Bubble});
      drive(8'hAA, 1'b1, 1'b0, 1'b0); step();
      drive(8'h00, 1'b0, 1'b0, 1'b0); step(); step();
      check("post_flush_c3", {24'h0, c3}, 32'hAA);
      check("post_flush_v3", {31'h0, v3}, 32'h1);
      check_cnts("mid");

      // Asynchronous reset between edges with DEPTH=3 full
      drive(8'hBB, 1'b1, 1'b0, 1'b0); step();
      drive(8'hCC, 1'b1, 1'b0, 1'b0); step();
      drive(8'hDD, 1'b1, 1'b0, 1'b0); step();
      #2 rst = 1'b1;
      #1;
      sb1.delete();
      sb3.delete();
      exp_stall = 0;
      exp_flush = 0;
      check("arst_sv3", {29'h0, sv3}, 32'h0);
      check("arst_c3", {24'h0, c3}, {24'h0, Bubble});
      check("arst_v3", {31'h0, v3}, 32'h0);
      check("arst_v1", {31'h0, v1}, 32'h0);
      check_cnts("arst");
      step();
      rst = 1'b0;
      drive(8'hE5, 1'b1, 1'b0, 1'b0); step();
      drive(8'h00, 1'b0, 1'b0, 1'b0); step();
      check("arst_lat_early", {31'h0, v3}, 32'h0);
      step();
      check("arst_lat3_c", {24'h0, c3}, 32'hE5);

      // Counter saturation and flush count
      drive(8'h00, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 70000; i++) step();
      check_cnts("sat");
      drive(8'h00, 1'b0, 1'b1, 1'b1);
      repeat (3) step();
      check_cnts("flush3");

      // Drain: nothing should be left expected
      drive(8'h00, 1'b0, 1'b0, 1'b0);
      repeat (3) step();
      check("drain_sb1", 32'(sb1.size()), 32'h0);
      check("drain_sb3", 32'(sb3.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
